// File: rtl/lu_decomp_nxn_pkg.sv
// Shared types and helpers for the N x N fixed-point LU decomposer.
// Packed matrices put element (0,0) in the MSBs (concatenation order).
package lu_decomp_nxn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPivot,
        StDiv,
        StUpd,
        StFin
    } lu_state_e;

    function automatic int unsigned elem_lsb(input int unsigned n, input int unsigned w,
                                             input int unsigned i, input int unsigned j);
        return ((n * n - 1) - (i * n + j)) * w;
    endfunction

endpackage

// File: rtl/lu_decomp_nxn_fx_div.sv
// Sequential signed fixed-point divider: (|num| << FRAC) / |den|, restoring, one bit per cycle.
// Quotient is truncated toward zero and saturated; result is valid while done_o is high.
module lu_decomp_nxn_fx_div #(
    parameter int unsigned W    = 32,
    parameter int unsigned FRAC = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] num_i,
    input  logic [W-1:0] den_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quot_o,
    output logic         ovf_o
);
    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] CntLast = CW'(W - 1);
    localparam logic [W-1:0] QMax = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] QMin = {1'b1, {(W - 1){1'b0}}};

    logic [W-1:0]  rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d;
    logic          neg_q, neg_d, pre_q, pre_d, busy_q, busy_d, done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  num_abs, den_abs, num_hi;
    logic [W:0]    shifted;
    logic          ge;
    logic          ovf;

    always_comb begin
        num_abs = num_i[W-1] ? W'(-num_i) : num_i;
        den_abs = den_i[W-1] ? W'(-den_i) : den_i;
        // Dividend bits above W: if they already reach the divisor, the quotient needs > W bits.
        num_hi  = num_abs >> (W - FRAC);
        shifted = {rem_q, dvd_q[W-1]};
        ge      = shifted >= {1'b0, dvs_q};
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        neg_d   = neg_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start_i && !busy_q) begin
            rem_d  = num_hi;
            dvd_d  = num_abs << FRAC;
            dvs_d  = den_abs;
            quo_d  = '0;
            neg_d  = num_i[W-1] ^ den_i[W-1];
            pre_d  = num_hi >= den_abs;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = ge ? W'(shifted - {1'b0, dvs_q}) : W'(shifted);
            dvd_d = dvd_q << 1;
            quo_d = {quo_q[W-2:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        if (!neg_q) begin
            ovf    = pre_q | quo_q[W-1];
            quot_o = ovf ? QMax : quo_q;
        end else begin
            ovf    = pre_q | (quo_q[W-1] & (|quo_q[W-2:0]));
            quot_o = ovf ? QMin : W'(-quo_q);
        end
        ovf_o = ovf;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            neg_q  <= 1'b0;
            pre_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            neg_q  <= neg_d;
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/lu_decomp_nxn.sv
// N x N Doolittle LU decomposer (no pivoting) in signed Q(W-FRAC).FRAC, in-place elimination
// on one shared multiply-subtract unit and one sequential divider.
module lu_decomp_nxn
    import lu_decomp_nxn_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned FRAC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N*N*W-1:0] a_in,
    output logic             busy,
    output logic             done,
    output logic             singular,
    output logic             ovf,
    output logic [N*N*W-1:0] l_out,
    output logic [N*N*W-1:0] u_out
);
    localparam int unsigned IW = $clog2(N);
    localparam logic [IW-1:0] Last = IW'(N - 1);
    localparam logic [W-1:0] QOne = W'(1) << FRAC;
    localparam logic [W-1:0] QMax = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] QMin = {1'b1, {(W - 1){1'b0}}};

    lu_state_e state_q, state_d;
    logic [IW-1:0] k_q, k_d, i_q, i_d, j_q, j_d;
    logic signed [W-1:0] m_q [N][N];
    logic signed [W-1:0] m_d [N][N];
    logic signed [W-1:0] l_q [N][N];
    logic signed [W-1:0] l_d [N][N];
    logic busy_q, busy_d, done_q, done_d, sing_q, sing_d, work_sing_q, work_sing_d, ovf_q, ovf_d;
    logic [N*N*W-1:0] l_out_q, l_out_d, u_out_q, u_out_d;

    logic                div_start, div_busy, div_done, div_ovf;
    logic [W-1:0]        div_num, div_den, div_quot;

    logic signed [W-1:0]   mac_a, mac_b, mac_c, mac_res;
    logic signed [2*W-1:0] mac_prod;
    logic signed [2*W:0]   mac_diff;
    logic                  mac_clip;

    // M[i][j] - floor(L[i][k] * M[k][j] / 2^FRAC), saturated to W bits.
    always_comb begin
        mac_a    = l_q[i_q][k_q];
        mac_b    = m_q[k_q][j_q];
        mac_c    = m_q[i_q][j_q];
        mac_prod = mac_a * mac_b;
        mac_diff = (2 * W + 1)'(mac_c) - (2 * W + 1)'(mac_prod >>> FRAC);
        mac_clip = (mac_diff[2*W:W-1] != {(W + 2){1'b0}}) &&
                   (mac_diff[2*W:W-1] != {(W + 2){1'b1}});
        mac_res  = mac_clip ? (mac_diff[2*W] ? QMin : QMax) : mac_diff[W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        i_d         = i_q;
        j_d         = j_q;
        m_d         = m_q;
        l_d         = l_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sing_d      = sing_q;
        work_sing_d = work_sing_q;
        ovf_d       = ovf_q;
        l_out_d     = l_out_q;
        u_out_d     = u_out_q;
        div_start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            m_d[r][c] = a_in[elem_lsb(N, W, r, c) +: W];
                            l_d[r][c] = (r == c) ? QOne : '0;
                        end
                    end
                    k_d         = '0;
                    work_sing_d = 1'b0;
                    ovf_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = StPivot;
                end
            end
            StPivot: begin
                if (k_q == Last) begin
                    state_d = StFin;
                end else if (m_q[k_q][k_q] == '0) begin
                    work_sing_d = 1'b1;
                    state_d     = StFin;
                end else begin
                    i_d       = k_q + 1'b1;
                    div_start = 1'b1;
                    state_d   = StDiv;
                end
            end
            StDiv: begin
                if (div_done) begin
                    l_d[i_q][k_q] = div_quot;
                    ovf_d         = ovf_q | div_ovf;
                    j_d           = k_q + 1'b1;
                    state_d       = StUpd;
                end
            end
            StUpd: begin
                m_d[i_q][j_q] = mac_res;
                m_d[i_q][k_q] = '0;
                ovf_d         = ovf_q | mac_clip;
                if (j_q != Last) begin
                    j_d = j_q + 1'b1;
                end else if (i_q != Last) begin
                    i_d       = i_q + 1'b1;
                    div_start = 1'b1;
                    state_d   = StDiv;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = StPivot;
                end
            end
            StFin: begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        l_out_d[elem_lsb(N, W, r, c) +: W] = l_q[r][c];
                        u_out_d[elem_lsb(N, W, r, c) +: W] = m_q[r][c];
                    end
                end
                sing_d  = work_sing_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Divider is issued on the edge entering DIV so the whole DIV stay is W+1 cycles.
        div_start = div_start & ~div_busy;
        div_num   = m_q[i_d][k_q];
        div_den   = m_q[k_q][k_q];
    end

    lu_decomp_nxn_fx_div #(
        .W    (W),
        .FRAC (FRAC)
    ) u_div (
        .clk_i   (clk),
        .rst_ni  (rst),
        .start_i (div_start),
        .num_i   (div_num),
        .den_i   (div_den),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quot_o  (div_quot),
        .ovf_o   (div_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sing_q      <= 1'b0;
            work_sing_q <= 1'b0;
            ovf_q       <= 1'b0;
            l_out_q     <= '0;
            u_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            i_q         <= i_d;
            j_q         <= j_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sing_q      <= sing_d;
            work_sing_q <= work_sing_d;
            ovf_q       <= ovf_d;
            l_out_q     <= l_out_d;
            u_out_q     <= u_out_d;
        end
    end

    // Working arrays are always written on accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        m_q <= m_d;
        l_q <= l_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign singular = sing_q;
    assign ovf      = ovf_q;
    assign l_out    = l_out_q;
    assign u_out    = u_out_q;

endmodule

// File: tb/tb_lu_decomp_nxn.sv
// Bench for lu_decomp_nxn: N=2 vector table and corner sequences, N=4 identity and
// randomized matrices against an arithmetic reference model.
module tb_lu_decomp_nxn;
    localparam int W    = 32;
    localparam int FRAC = 16;
    localparam int ONE  = 65536;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic           start2, busy2, done2, sing2, ovf2;
    logic [4*W-1:0] a2, l2, u2;
    logic            start4, busy4, done4, sing4, ovf4;
    logic [16*W-1:0] a4, l4, u4;

    lu_decomp_nxn #(.N(2), .W(W), .FRAC(FRAC)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_in(a2), .busy(busy2), .done(done2),
        .singular(sing2), .ovf(ovf2), .l_out(l2), .u_out(u2)
    );
    lu_decomp_nxn #(.N(4), .W(W), .FRAC(FRAC)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .busy(busy4), .done(done4),
        .singular(sing4), .ovf(ovf4), .l_out(l4), .u_out(u4)
    );

    int errs = 0;
    int checks = 0;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [4*W-1:0] a;
        logic [4*W-1:0] l;
        logic [4*W-1:0] u;
        bit             chk_lu;
        bit             sing;
        bit             ovf;
        int             lat;
    } vec_t;
    vec_t vecs[5];

    task automatic run2(input logic [4*W-1:0] a, output int lat);
        @(negedge clk);
        a2 = a;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run4(input logic [16*W-1:0] a, output int lat);
        @(negedge clk);
        a4 = a;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic bit clips(input longint x);
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    function automatic longint clamp(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    // Textbook Doolittle elimination on exact integers, with the fixed-point rounding rules.
    task automatic ref_lu4(input logic [16*W-1:0] a, output logic [16*W-1:0] l,
                           output logic [16*W-1:0] u, output bit ovf, output bit sing);
        longint m [4][4];
        longint lm[4][4];
        longint q;
        bit stop;
        ovf = 1'b0;
        sing = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                m[i][j]  = longint'($signed(a[(15 - (i * 4 + j)) * W +: W]));
                lm[i][j] = (i == j) ? ONE : 0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (!stop) begin
                if (m[k][k] == 0) begin
                    sing = 1'b1;
                    stop = 1'b1;
                end else begin
                    for (int i = k + 1; i < 4; i++) begin
                        q = (m[i][k] * ONE) / m[k][k];
                        ovf |= clips(q);
                        lm[i][k] = clamp(q);
                        for (int j = k + 1; j < 4; j++) begin
                            q = m[i][j] - ((lm[i][k] * m[k][j]) >>> FRAC);
                            ovf |= clips(q);
                            m[i][j] = clamp(q);
                        end
                        m[i][k] = 0;
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                l[(15 - (i * 4 + j)) * W +: W] = lm[i][j][W-1:0];
                u[(15 - (i * 4 + j)) * W +: W] = m[i][j][W-1:0];
            end
        end
    endtask

    initial begin
        int lat;
        int dones;
        int first;
        logic [16*W-1:0] ra, el, eu, ident;
        bit eovf, esing;

        vecs[0] = '{{32'h00040000, 32'h00030000, 32'h00060000, 32'h00030000},
                    {32'h00010000, 32'h0, 32'h00018000, 32'h00010000},
                    {32'h00040000, 32'h00030000, 32'h0, 32'hFFFE8000}, 1'b1, 1'b0, 1'b0, 37};
        vecs[1] = '{{32'h0, 32'h00010000, 32'h00010000, 32'h0}, '0, '0, 1'b0, 1'b1, 1'b0, 2};
        vecs[2] = '{{32'h00000001, 32'h00010000, 32'h40000000, 32'h00010000},
                    {32'h00010000, 32'h0, 32'h7FFFFFFF, 32'h00010000},
                    {32'h00000001, 32'h00010000, 32'h0, 32'h80010001}, 1'b1, 1'b0, 1'b1, 37};
        vecs[3] = '{{32'h00020000, 32'h00010000, 32'h00010000, 32'h00030000},
                    {32'h00010000, 32'h0, 32'h00008000, 32'h00010000},
                    {32'h00020000, 32'h00010000, 32'h0, 32'h00028000}, 1'b1, 1'b0, 1'b0, 37};
        vecs[4] = '{{32'hFFFE0000, 32'h00010000, 32'h00030000, 32'hFFFF0000},
                    {32'h00010000, 32'h0, 32'hFFFE8000, 32'h00010000},
                    {32'hFFFE0000, 32'h00010000, 32'h0, 32'h00008000}, 1'b1, 1'b0, 1'b0, 37};

        rst = 1'b0;
        start2 = 1'b0;
        start4 = 1'b0;
        a2 = '0;
        a4 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 512'(busy2), 512'(0));
        check("reset_done", 512'(done2), 512'(0));
        check("reset_flags", 512'({sing2, ovf2}), 512'(0));
        check("reset_lu", 512'({l2, u2}), 512'(0));
        check("reset_n4", 512'({busy4, done4, sing4, ovf4}), 512'(0));
        rst = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run2(vecs[v].a, lat);
            check($sformatf("v%0d_latency", v), 512'(lat), 512'(vecs[v].lat));
            check($sformatf("v%0d_busy_at_done", v), 512'(busy2), 512'(0));
            check($sformatf("v%0d_singular", v), 512'(sing2), 512'(vecs[v].sing));
            check($sformatf("v%0d_ovf", v), 512'(ovf2), 512'(vecs[v].ovf));
            if (vecs[v].chk_lu) begin
                check($sformatf("v%0d_L", v), 512'(l2), 512'(vecs[v].l));
                check($sformatf("v%0d_U", v), 512'(u2), 512'(vecs[v].u));
            end
        end

        // start pulses mid-run must be ignored
        @(negedge clk);
        a2 = vecs[0].a;
        start2 = 1'b1;
        @(negedge clk);
        dones = 0;
        first = -1;
        for (int n = 0; n < 80; n++) begin
            if (done2) begin
                dones++;
                if (first < 0) first = n;
            end
            start2 = (n == 4 || n == 19);
            if (n == 4) a2 = vecs[3].a;
            @(negedge clk);
        end
        start2 = 1'b0;
        check("ignore_start_dones", 512'(dones), 512'(1));
        check("ignore_start_latency", 512'(first), 512'(37));
        check("ignore_start_L", 512'(l2), 512'(vecs[0].l));

        // reset mid-run aborts with no done
        @(negedge clk);
        a2 = vecs[3].a;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 512'(busy2), 512'(0));
        check("abort_done", 512'(done2), 512'(0));
        check("abort_lu", 512'({l2, u2}), 512'(0));
        check("abort_flags", 512'({sing2, ovf2}), 512'(0));
        rst = 1'b1;
        dones = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done2) dones++;
        end
        check("abort_no_done", 512'(dones), 512'(0));

        // back-to-back: start presented during the done cycle
        run2(vecs[0].a, lat);
        check("b2b_first_L", 512'(l2), 512'(vecs[0].l));
        a2 = vecs[4].a;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("b2b_busy_after_accept", 512'(busy2), 512'(1));
        check("b2b_hold_U", 512'(u2), 512'(vecs[0].u));
        lat = 0;
        while (!done2 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_latency", 512'(lat), 512'(37));
        check("b2b_second_L", 512'(l2), 512'(vecs[4].l));
        check("b2b_second_U", 512'(u2), 512'(vecs[4].u));

        // N=4 identity
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                ident[(15 - (i * 4 + j)) * W +: W] = (i == j) ? 32'h00010000 : 32'h0;
        run4(ident, lat);
        check("n4_ident_latency", 512'(lat), 512'(217));
        check("n4_ident_L", 512'(l4), 512'(ident));
        check("n4_ident_U", 512'(u4), 512'(ident));
        check("n4_ident_flags", 512'({sing4, ovf4}), 512'(0));

        // N=4 random diagonally dominant matrices
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    int val;
                    if (i == j) begin
                        val = 524288 + int'($urandom_range(0, 524288));
                        if ($urandom_range(0, 1) == 1) val = -val;
                    end else begin
                        val = int'($urandom_range(0, 262144)) - 131072;
                    end
                    ra[(15 - (i * 4 + j)) * W +: W] = val;
                end
            end
            ref_lu4(ra, el, eu, eovf, esing);
            run4(ra, lat);
            check($sformatf("rnd%0d_latency", t), 512'(lat), 512'(217));
            check($sformatf("rnd%0d_L", t), 512'(l4), 512'(el));
            check($sformatf("rnd%0d_U", t), 512'(u4), 512'(eu));
            check($sformatf("rnd%0d_flags", t), 512'({sing4, ovf4}), 512'({esing, eovf}));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
